// File: rtl/trunc_prod_accum_if.sv
// Handshake bundle for trunc_prod_accum.
//   master: drives start/len, the term stream (in_valid/prod) and out_ready.
//   slave : drives in_ready, out_valid, acc_out, ovf and busy.
interface trunc_prod_accum_if #(
    parameter int unsigned ACC_W = 6,
    parameter int unsigned LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, prod, out_ready,
        input  in_ready, out_valid, acc_out, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, prod, out_ready,
        output in_ready, out_valid, acc_out, ovf, busy
    );
endinterface

// File: rtl/trunc_prod_accum.sv
// Saturating accumulator for the 4-bit truncated product stream.
// Sums `len` terms (captured on start) into an ACC_W-bit unsigned register
// that clamps at all-ones; ovf is sticky for the current accumulation.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : trunc_prod_accum_if.slave (start/len, in_valid/in_ready/prod,
//                out_valid/out_ready, acc_out, ovf, busy)
module trunc_prod_accum #(
    parameter int unsigned ACC_W = 6,
    parameter int unsigned LEN_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    trunc_prod_accum_if.slave   bus
);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [LEN_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [SUM_W-1:0] sum;

    // Next-state, datapath and registered status decodes
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum         = {1'b0, acc_q} + SUM_W'(bus.prod);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    // Carry out of the widened sum means the true total exceeds ACC_MAX
                    if (sum[ACC_W]) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake flags are registered copies of the next state, so they
        // never depend combinationally on in_valid/out_ready.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.acc_out   = acc_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_trunc_prod_accum.sv
// Self-checking bench for trunc_prod_accum: directed scenarios plus random
// jobs, compared against a job-level reference (running clamped sum).
module tb_trunc_prod_accum;
    localparam int unsigned ACC_W = 6;
    localparam int unsigned LEN_W = 4;
    localparam int          MAXV  = (1 << ACC_W) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int   dir_prod[$];
    bit   dir_valid[$];

    trunc_prod_accum_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    trunc_prod_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy"},      32'(bus.busy),      0);
    endtask

    task automatic chk_done(input string tag, input int total);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  0);
        chk({tag, "_busy"},      32'(bus.busy),      1);
        chk({tag, "_acc_out"},   32'(bus.acc_out),   32'(clamp(total)));
        chk({tag, "_ovf"},       32'(bus.ovf),       32'(total > MAXV));
    endtask

    // One complete job starting from IDLE. Terms come from dir_prod/dir_valid
    // when populated, otherwise random. noise pulses start where it must be ignored.
    task automatic run_job(input string tag, input int n, input int bubble_pct,
                           input int stall, input bit noise, output int total);
        int  taken;
        int  guard;
        int  p;
        bit  v;
        total = 0;
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        tick();
        bus.start = 1'b0;
        taken = 0;
        guard = 0;
        while (taken < n && guard < 300) begin
            chk({tag, "_acc_in_ready"}, 32'(bus.in_ready), 1);
            chk({tag, "_acc_out_valid"}, 32'(bus.out_valid), 0);
            chk({tag, "_acc_partial"}, 32'(bus.acc_out), 32'(clamp(total)));
            chk({tag, "_acc_ovf"}, 32'(bus.ovf), 32'(total > MAXV));
            if (dir_valid.size() > 0) v = dir_valid.pop_front();
            else                      v = ($urandom_range(99) >= bubble_pct);
            if (v && dir_prod.size() > 0) p = dir_prod.pop_front();
            else                          p = $urandom_range(15);
            bus.in_valid = v;
            bus.prod     = 4'(p);
            bus.start    = noise ? 1'($urandom_range(1)) : 1'b0;
            bus.len      = LEN_W'($urandom_range(15));
            tick();
            if (v) begin
                total += p;
                taken++;
            end
            guard++;
        end
        if (guard >= 300) chk({tag, "_term_budget"}, 32'(guard), 32'(n));
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk_done({tag, "_done"}, total);
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            bus.start     = noise ? 1'($urandom_range(1)) : 1'b0;
            tick();
            chk_done({tag, "_stall"}, total);
        end
        // Handshake cycle; a start here must not begin a new job
        bus.out_ready = 1'b1;
        bus.start     = noise;
        bus.len       = LEN_W'(3);
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk_idle({tag, "_after"});
        chk({tag, "_after_acc_held"}, 32'(bus.acc_out), 32'(clamp(total)));
        tick();
        chk_idle({tag, "_idle2"});
    endtask

    initial begin
        int tot;
        checks   = 0;
        failures = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.prod      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_acc_out", 32'(bus.acc_out), 0);
        chk("reset_ovf",     32'(bus.ovf),     0);
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // Basic: 5+7+15
        dir_prod = '{5, 7, 15};
        run_job("basic", 3, 0, 0, 1'b0, tot);
        chk("basic_total", 32'(tot), 27);

        // Saturation: 15 x5 clamps to 63 with ovf
        dir_prod = '{15, 15, 15, 15, 15};
        run_job("sat", 5, 0, 0, 1'b0, tot);

        // Bubbles then 5 cycles of backpressure
        dir_valid = '{1, 0, 0, 1, 1, 0, 1};
        dir_prod  = '{1, 2, 3, 4};
        run_job("bubble", 4, 0, 5, 1'b0, tot);
        chk("bubble_total", 32'(tot), 10);

        // Zero length: DONE directly, in_ready never seen high
        run_job("zero", 0, 0, 1, 1'b0, tot);

        // Ignored starts during ACCUM, stall and handshake
        run_job("noise", 6, 30, 2, 1'b1, tot);

        // Reset mid-accumulation
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.prod     = 4'd5;
        tick();
        bus.prod     = 4'd4;
        tick();
        bus.in_valid = 1'b0;
        chk("midrst_partial", 32'(bus.acc_out), 9);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst_async");
        chk("midrst_acc_out", 32'(bus.acc_out), 0);
        chk("midrst_ovf",     32'(bus.ovf),     0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("midrst_release");
        dir_prod = '{3};
        run_job("midrst_fresh", 1, 0, 0, 1'b0, tot);
        chk("midrst_fresh_total", 32'(tot), 3);

        // Random jobs
        for (int j = 0; j < 25; j++) begin
            run_job("rand", $urandom_range(15), 25, $urandom_range(3), 1'($urandom_range(1)), tot);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
